// File: rtl/sa_feeder.sv
// Operand-skew and control stage feeding the systolic array: accepts A columns / B rows,
// skews them diagonally, pulses per-PE clc latches and drains rows. Optional: SA_FEEDER_STALL_CNT_EN.
module sa_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROW    = 8,
  parameter int NUM_COL    = 8,
  parameter int K_MAX      = 64,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [NUM_ROW*DATA_WIDTH-1:0]  a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [NUM_COL*DATA_WIDTH-1:0]  b_data,
  output logic                           sa_en,
  output logic [NUM_ROW*DATA_WIDTH-1:0]  sa_row_in,
  output logic [NUM_COL*DATA_WIDTH-1:0]  sa_col_in,
  output logic [NUM_ROW*NUM_COL-1:0]     sa_clc,
  output logic [NUM_ROW-1:0]             sa_row_out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    stall_cnt
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(K_MAX + NUM_ROW + NUM_COL);
  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam logic [NUM_ROW-1:0] ROW_ONE = NUM_ROW'(1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q;
  logic [KW-1:0]            k_clamp;
  logic [CW-1:0]            cnt_q;
  logic [CW-1:0]            k_ext;
  logic [CW-1:0]            last_cnt;
  logic [RW-1:0]            row_q;
  logic                     done_q, done_d;
  logic                     fire;
  logic [NUM_ROW*DW-1:0]    a_beat;
  logic [NUM_COL*DW-1:0]    b_beat;

  assign k_clamp  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign k_ext    = CW'(k_q);
  assign last_cnt = k_ext + CW'(NUM_ROW + NUM_COL - 2);

  assign fire    = (state_q == FEED) && a_valid && b_valid;
  assign a_ready = fire;
  assign b_ready = fire;
  assign sa_en   = fire || (state_q == FLUSH);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  // Flush beats are zeros; gating by fire also keeps pass-through lanes quiet while stalled.
  assign a_beat = fire ? a_data : '0;
  assign b_beat = fire ? b_data : '0;

  assign sa_row_out_valid = (state_q == DRAIN) ? (ROW_ONE << row_q) : '0;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (k_clamp != '0) state_d = FEED;
          else               done_d  = 1'b1;
        end
      end
      FEED:  if (fire && (cnt_q == k_ext - CW'(1))) state_d = FLUSH;
      FLUSH: if (cnt_q == last_cnt) state_d = DRAIN;
      DRAIN: begin
        if (out_ready && (row_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if ((state_q == IDLE) && start) begin
        k_q   <= k_clamp;
        cnt_q <= '0;
      end else if (sa_en) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if ((state_q == FLUSH) && (state_d == DRAIN))
        row_q <= RW'(NUM_ROW - 1);
      else if ((state_q == DRAIN) && out_ready && (row_q != '0))
        row_q <= row_q - RW'(1);
    end
  end

  // A lane i is delayed NUM_ROW-1-i enabled cycles; the last lane passes straight through.
  for (genvar i = 0; i < NUM_ROW; i++) begin : g_a_skew
    localparam int D = NUM_ROW - 1 - i;
    if (D == 0) begin : g_pass
      assign sa_row_in[i*DW +: DW] = a_beat[i*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [D];
      // NOTE: the skew memory is reset so an aborted tile cannot leak stale operands into the next.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < D; s++) sr[s] <= '0;
        end else if (sa_en) begin
          sr[0] <= a_beat[i*DW +: DW];
          for (int s = 1; s < D; s++) sr[s] <= sr[s-1];
        end
      end
      assign sa_row_in[i*DW +: DW] = sr[D-1];
    end
  end

  for (genvar j = 0; j < NUM_COL; j++) begin : g_b_skew
    localparam int D = NUM_COL - 1 - j;
    if (D == 0) begin : g_pass
      assign sa_col_in[j*DW +: DW] = b_beat[j*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < D; s++) sr[s] <= '0;
        end else if (sa_en) begin
          sr[0] <= b_beat[j*DW +: DW];
          for (int s = 1; s < D; s++) sr[s] <= sr[s-1];
        end
      end
      assign sa_col_in[j*DW +: DW] = sr[D-1];
    end
  end

  // PE(i+1,j+1) latches once its last skewed product has arrived.
  for (genvar i = 0; i < NUM_ROW; i++) begin : g_clc_r
    for (genvar j = 0; j < NUM_COL; j++) begin : g_clc_c
      assign sa_clc[i*NUM_COL + j] =
        sa_en && (cnt_q == k_ext + CW'((NUM_ROW - 1 - i) + (NUM_COL - 1 - j)));
    end
  end

`ifdef SA_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_q <= '0;
    else if ((state_q == IDLE) && start)
      stall_q <= '0;
    else if ((state_q == FEED) && !fire && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder with a 4x4 array: reset, zero-length start, skew/clc timing,
// stalls, drain back-pressure, ignored start, mid-tile reset and k_len clamping.
module tb_sa_feeder;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int KM = 64;
  localparam int KW = $clog2(KM + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [KW-1:0]    k_len;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [NR*DW-1:0] a_data;
  logic [NC*DW-1:0] b_data;
  logic             sa_en;
  logic [NR*DW-1:0] sa_row_in;
  logic [NC*DW-1:0] sa_col_in;
  logic [NR*NC-1:0] sa_clc;
  logic [NR-1:0]    sa_row_out_valid;
  logic             out_ready, busy, done;
  logic [31:0]      stall_cnt;

  int errors = 0;
  int checks = 0;

  // per-tile observations
  int n_fire, n_en, n_gap, n_rov, n_rov3, n_done, onehot_err, done_cyc, first_rov_cyc;
  int busy_at_done;
  int clc_cyc [NR*NC];
  int clc_n   [NR*NC];
  logic [DW-1:0] row1_en3, row4_en0, row4_en1, col1_en3, col2_en2;
  logic [NR-1:0] first_rov;

  sa_feeder #(.DATA_WIDTH(DW), .NUM_ROW(NR), .NUM_COL(NC), .K_MAX(KM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .sa_en(sa_en), .sa_row_in(sa_row_in), .sa_col_in(sa_col_in), .sa_clc(sa_clc),
    .sa_row_out_valid(sa_row_out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A lane r beat t = 16*r + t + 1; B lane c beat t = 0x80 + 16*c + t + 1
  function automatic logic [NR*DW-1:0] beat_a(input int t);
    logic [NR*DW-1:0] v;
    for (int r = 1; r <= NR; r++) v[(r-1)*DW +: DW] = 8'(16*r + t + 1);
    return v;
  endfunction

  function automatic logic [NC*DW-1:0] beat_b(input int t);
    logic [NC*DW-1:0] v;
    for (int c = 1; c <= NC; c++) v[(c-1)*DW +: DW] = 8'(128 + 16*c + t + 1);
    return v;
  endfunction

  // Starts a tile and runs it to done; called right after a posedge (+1).
  task automatic run_tile(input int k, input int stall_at, input int stall_len,
                          input int hold_len, input bit mid_start);
    int cyc, stall_left, hold_left;
    bit fin;
    start = 1'b1; k_len = KW'(k); a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n_fire = 0; n_en = 0; n_gap = 0; n_rov = 0; n_rov3 = 0; n_done = 0; onehot_err = 0;
    done_cyc = -1; first_rov_cyc = -1; busy_at_done = -1; first_rov = '0;
    for (int b = 0; b < NR*NC; b++) begin clc_cyc[b] = -1; clc_n[b] = 0; end
    cyc = 0; stall_left = stall_len; hold_left = hold_len; fin = 1'b0;
    while (!fin && cyc < 400) begin
      a_valid   = 1'b1;
      b_valid   = !(n_fire == stall_at && stall_left > 0);
      a_data    = beat_a(n_fire);
      b_data    = beat_b(n_fire);
      out_ready = !(sa_row_out_valid == 4'b0100 && hold_left > 0);
      start     = mid_start && (cyc == 1);
      if (mid_start && cyc == 1) k_len = KW'(20);
      @(negedge clk);
      if (!b_valid && stall_left > 0) stall_left--;
      if (sa_en) begin
        if (n_en == 0) begin row4_en0 = sa_row_in[3*DW +: DW]; end
        if (n_en == 1) begin row4_en1 = sa_row_in[3*DW +: DW]; end
        if (n_en == 2) begin col2_en2 = sa_col_in[1*DW +: DW]; end
        if (n_en == 3) begin row1_en3 = sa_row_in[0 +: DW]; col1_en3 = sa_col_in[0 +: DW]; end
        for (int b = 0; b < NR*NC; b++)
          if (sa_clc[b]) begin clc_n[b]++; clc_cyc[b] = cyc; end
        n_en++;
      end else if (busy && sa_row_out_valid == '0) begin
        n_gap++;
      end
      if (a_ready && b_ready) n_fire++;
      if (sa_row_out_valid != '0) begin
        if (first_rov_cyc < 0) begin first_rov_cyc = cyc; first_rov = sa_row_out_valid; end
        n_rov++;
        if (sa_row_out_valid == 4'b0100) n_rov3++;
        if (!$onehot(sa_row_out_valid)) onehot_err++;
        if (sa_row_out_valid == 4'b0100 && !out_ready && hold_left > 0) hold_left--;
      end
      if (done) begin
        n_done++; done_cyc = cyc; busy_at_done = int'(busy); fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    check("tile_finished", fin, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ready"}, a_ready, 0);
    check({tag, "_b_ready"}, b_ready, 0);
    check({tag, "_sa_en"},   sa_en, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    done, 0);
    check({tag, "_clc"},     sa_clc, 0);
    check({tag, "_rov"},     sa_row_out_valid, 0);
    check({tag, "_row_in"},  sa_row_in, 0);
    check({tag, "_col_in"},  sa_col_in, 0);
    check({tag, "_stall"},   stall_cnt, 0);
  endtask

  task automatic check_clc_once(input string tag);
    int bad;
    bad = 0;
    for (int b = 0; b < NR*NC; b++) if (clc_n[b] != 1) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; k_len = '0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // zero-length start: done one cycle later, no activity
    start = 1'b1; k_len = '0;
    @(negedge clk);
    check("k0_en_at_start", sa_en, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("k0_done", done, 1);
    check("k0_busy", busy, 0);
    check("k0_en", sa_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("k0_done_clear", done, 0);
    @(posedge clk); #1;

    // k=3, continuous valid
    run_tile(3, -1, 0, 0, 1'b0);
    check("t1_fires", n_fire, 3);
    check("t1_en_cycles", n_en, 10);
    check("t1_gap", n_gap, 0);
    check("t1_clc44_cyc", clc_cyc[15], 3);
    check("t1_clc11_cyc", clc_cyc[0], 9);
    check("t1_clc41_cyc", clc_cyc[12], 6);
    check_clc_once("t1_clc_once");
    check("t1_row1_en3", row1_en3, 8'h11);
    check("t1_row4_en0", row4_en0, 8'h41);
    check("t1_row4_en1", row4_en1, 8'h42);
    check("t1_col1_en3", col1_en3, 8'h91);
    check("t1_col2_en2", col2_en2, 8'hA1);
    check("t1_first_rov_cyc", first_rov_cyc, 10);
    check("t1_first_rov", first_rov, 4'b1000);
    check("t1_rov_cycles", n_rov, 4);
    check("t1_onehot", onehot_err, 0);
    check("t1_done_cyc", done_cyc, 14);
    check("t1_busy_at_done", busy_at_done, 0);

    // same tile, b_valid dropped for 2 cycles after the first beat
    run_tile(3, 1, 2, 0, 1'b0);
    check("t2_fires", n_fire, 3);
    check("t2_en_cycles", n_en, 10);
    check("t2_gap", n_gap, 2);
    check("t2_clc44_cyc", clc_cyc[15], 5);
    check("t2_clc11_cyc", clc_cyc[0], 11);
    check_clc_once("t2_clc_once");
    check("t2_row4_en1", row4_en1, 8'h42);
    check("t2_row1_en3", row1_en3, 8'h11);
    check("t2_done_cyc", done_cyc, 16);
`ifdef SA_FEEDER_STALL_CNT_EN
    check("t2_stall_cnt", stall_cnt, 2);
`else
    check("t2_stall_cnt", stall_cnt, 0);
`endif

    // out_ready low 3 cycles while row 3 is selected
    run_tile(3, -1, 0, 3, 1'b0);
    check("t3_rov3_cycles", n_rov3, 4);
    check("t3_rov_cycles", n_rov, 7);
    check("t3_onehot", onehot_err, 0);
    check("t3_done_cyc", done_cyc, 17);
    check("t3_done_count", n_done, 1);

    // start pulsed during FEED is ignored
    run_tile(3, -1, 0, 0, 1'b1);
    check("t4_fires", n_fire, 3);
    check("t4_en_cycles", n_en, 10);
    check("t4_clc11_cyc", clc_cyc[0], 9);
    check("t4_done_cyc", done_cyc, 14);

    // reset during FLUSH aborts the tile
    start = 1'b1; k_len = KW'(3);
    @(posedge clk); #1;
    start = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = beat_a(0); b_data = beat_b(0);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre_in_flush", sa_en && busy && !a_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || sa_clc != '0 || sa_en) seen++;
    end
    check("midrst_quiet", seen, 0);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // k_len above K_MAX clamps to 64 fires
    run_tile(100, -1, 0, 0, 1'b0);
    check("t6_fires", n_fire, 64);
    check("t6_en_cycles", n_en, 71);
    check("t6_clc11_cyc", clc_cyc[0], 70);
    check_clc_once("t6_clc_once");
    check("t6_done_cyc", done_cyc, 75);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
